// File: rtl/sopc_mem_arbiter_if.sv
// rtl/sopc_mem_arbiter_if.sv - CPU-master and memory-slave signal bundle for the SOPC memory arbiter
interface sopc_mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  m0_req;
    logic [ADDR_W-1:0]     m0_addr;
    logic [DATA_W-1:0]     m0_rdata;
    logic                  m0_ack;

    logic                  m1_req;
    logic                  m1_we;
    logic [ADDR_W-1:0]     m1_addr;
    logic [DATA_W/8-1:0]   m1_sel;
    logic [DATA_W-1:0]     m1_wdata;
    logic [DATA_W-1:0]     m1_rdata;
    logic                  m1_ack;

    logic                  mem_ce;
    logic                  mem_we;
    logic [ADDR_W-1:0]     mem_addr;
    logic [DATA_W/8-1:0]   mem_sel;
    logic [DATA_W-1:0]     mem_wdata;
    logic [DATA_W-1:0]     mem_rdata;
    logic                  mem_ready;

    logic                  stall_req;
    logic                  err;

    // Arbiter side
    modport slave (
        input  m0_req, m0_addr,
        output m0_rdata, m0_ack,
        input  m1_req, m1_we, m1_addr, m1_sel, m1_wdata,
        output m1_rdata, m1_ack,
        output mem_ce, mem_we, mem_addr, mem_sel, mem_wdata,
        input  mem_rdata, mem_ready,
        output stall_req, err
    );

    // Environment side (CPU masters plus memory)
    modport master (
        output m0_req, m0_addr,
        input  m0_rdata, m0_ack,
        output m1_req, m1_we, m1_addr, m1_sel, m1_wdata,
        input  m1_rdata, m1_ack,
        input  mem_ce, mem_we, mem_addr, mem_sel, mem_wdata,
        output mem_rdata, mem_ready,
        input  stall_req, err
    );
endinterface

// File: rtl/sopc_mem_arbiter.sv
// rtl/sopc_mem_arbiter.sv - two-master round-robin memory arbiter with ready handshake
// Optional slave-wait watchdog enabled by defining ARB_TIMEOUT_EN.
module sopc_mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    sopc_mem_arbiter_if.slave bus
);
    localparam int SEL_W = DATA_W / 8;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t              state, state_nx;
    logic                grant, grant_nx;
    logic                last;
    logic                done;
    logic                timeout_hit;
    logic [ADDR_W-1:0]   addr_q;
    logic                we_q;
    logic [SEL_W-1:0]    sel_q;
    logic [DATA_W-1:0]   wdata_q;

`ifdef ARB_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);
    logic [7:0] wait_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            wait_cnt <= 8'd0;
        else if (state == IDLE)
            wait_cnt <= 8'd0;
        else if (!bus.mem_ready)
            wait_cnt <= wait_cnt + 8'd1;
    end

    // A real ready in the limit cycle wins over the watchdog
    assign timeout_hit = (state == BUSY) && !bus.mem_ready && (wait_cnt == TIMEOUT_C);
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx      = state;
        grant_nx      = grant;
        done          = 1'b0;
        case (state)
            IDLE: begin
                if (bus.m0_req || bus.m1_req) begin
                    grant_nx = (bus.m0_req && bus.m1_req) ? ~last : bus.m1_req;
                    state_nx = BUSY;
                end
            end
            BUSY: begin
                if (bus.mem_ready || timeout_hit) begin
                    done     = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant   <= 1'b0;
            last    <= 1'b1;
            addr_q  <= '0;
            we_q    <= 1'b0;
            sel_q   <= '0;
            wdata_q <= '0;
        end else begin
            grant <= grant_nx;
            if (state == IDLE && state_nx == BUSY) begin
                if (grant_nx) begin
                    addr_q  <= bus.m1_addr;
                    we_q    <= bus.m1_we;
                    sel_q   <= bus.m1_sel;
                    wdata_q <= bus.m1_wdata;
                end else begin
                    addr_q  <= bus.m0_addr;
                    we_q    <= 1'b0;
                    sel_q   <= '1;
                    wdata_q <= '0;
                end
            end
            if (done)
                last <= grant;
        end
    end

    // Slave-side outputs are gated by BUSY so reset clears them without a clock
    always_comb begin
        bus.mem_ce    = (state == BUSY);
        bus.mem_we    = (state == BUSY) && we_q;
        bus.mem_addr  = (state == BUSY) ? addr_q  : '0;
        bus.mem_sel   = (state == BUSY) ? sel_q   : '0;
        bus.mem_wdata = (state == BUSY) ? wdata_q : '0;
        bus.m0_ack    = done && !grant;
        bus.m1_ack    = done && grant;
        bus.m0_rdata  = (done && !grant && !timeout_hit) ? bus.mem_rdata : '0;
        bus.m1_rdata  = (done && grant && !timeout_hit)  ? bus.mem_rdata : '0;
        bus.err       = timeout_hit;
        bus.stall_req = (bus.m0_req && !bus.m0_ack) || (bus.m1_req && !bus.m1_ack);
    end
endmodule
